// File: rtl/button_pkg.sv
// Shared types and constants for the push-button front end (button_debounce, button_sync).
package button_pkg;

  // Encoding is chosen so that bit 1 is the debounced level and bit 0 is the
  // "qualifying" flag; the debouncer outputs are the state bits themselves.
  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_RISE_CHK = 2'd1,
    ST_HIGH     = 2'd2,
    ST_FALL_CHK = 2'd3
  } btn_state_e;

  // 10 ms at 100 MHz.
  localparam int unsigned DB_CYCLES_DEFAULT = 1000000;

endpackage : button_pkg

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer, asynchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronizes the raw pin, then accepts a level change
// only after it has been seen for DB_CYCLES+1 consecutive samples.
// Build option: define BUTTON_DEBOUNCE_SYNC_EN to put a two-flop synchronizer
// on btn_raw (real pins); leave it undefined for a single input register when
// btn_raw is already synchronous to clk.
module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_db,
  output logic bouncing
);

  localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             btn_s;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef BUTTON_DEBOUNCE_SYNC_EN
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (btn_raw),
    .q_o (btn_s)
  );
`else
  logic btn_s_q;

  // Single input register; btn_raw is already in the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_s_q <= 1'b0;
    else     btn_s_q <= btn_raw;
  end

  assign btn_s = btn_s_q;
`endif

  // State and qualification counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic; a contrary sample aborts qualification.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_LOW: begin
        if (btn_s) begin
          state_d = ST_RISE_CHK;
          cnt_d   = '0;
        end
      end
      ST_RISE_CHK: begin
        if (!btn_s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!btn_s) begin
          state_d = ST_FALL_CHK;
          cnt_d   = '0;
        end
      end
      ST_FALL_CHK: begin
        if (btn_s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore outputs taken straight from the registered state bits.
  assign btn_db   = state_q[1];
  assign bouncing = state_q[0];

endmodule : button_debounce

// File: doc/button_debounce.md
# button_debounce

Cleans a raw, bouncing push-button input into a stable level for the `button_sync` edge-pulse stage directly downstream. The raw pin is first brought into the `clk` domain by a synchronizer. A four-state FSM with a qualification counter then accepts a level change only after it has held for `DB_CYCLES` consecutive cycles. `btn_db` connects directly to `button_sync.a`.

## Interface
- `DB_CYCLES`, default 1000000: qualification length in `clk` cycles (10 ms at 100 MHz). Legal range is ≥1.
- `CNT_W`, derived localparam, not overridable: `$clog2(DB_CYCLES)`, minimum 1.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `btn_raw`, input, 1: raw button pin. Asynchronous and may bounce.
- `btn_db`, output, 1: debounced level. Feeds `button_sync.a`.
- `bouncing`, output, 1: high while a candidate level change is being qualified.

## Operation
- **Synchronized sample `btn_s`:** the output of the input synchronizer (see Configuration).
- **FSM states:**
  - `ST_LOW`: `btn_db`=0, `bouncing`=0.
  - `ST_RISE_CHK`: `btn_db`=0, `bouncing`=1.
  - `ST_HIGH`: `btn_db`=1, `bouncing`=0.
  - `ST_FALL_CHK`: `btn_db`=1, `bouncing`=1.
  - Outputs are Moore, decoded from the registered state only. There is no combinational path from `btn_raw`.
- **Transitions:**
  - `ST_LOW`: if `btn_s`=1, go to `ST_RISE_CHK` and clear `cnt` to 0. Otherwise stay.
  - `ST_RISE_CHK`:
    - if `btn_s`=0, go to `ST_LOW` and clear `cnt` (bounce rejected).
    - else if `cnt`==`DB_CYCLES`-1, go to `ST_HIGH` and clear `cnt`.
    - else `cnt`+1.
  - `ST_HIGH`: if `btn_s`=0, go to `ST_FALL_CHK` and clear `cnt`. Otherwise stay.
  - `ST_FALL_CHK`: mirror of `ST_RISE_CHK` with polarity inverted. A glitch (`btn_s`=1) returns to `ST_HIGH`. Qualification ends in `ST_LOW`.
  - Illegal state encodings go to `ST_LOW` with `cnt` cleared.
- **Counter:** `cnt` is `CNT_W` bits wide. It never exceeds `DB_CYCLES`-1, so it never wraps.
- **`DB_CYCLES`=1:** a single confirming sample suffices. `cnt` stays 0.
- **Reset values:** synchronizer flops 0, state `ST_LOW`, `cnt` 0, `btn_db`=0, `bouncing`=0.
- **Reset asserted mid-qualification:** abandons the check immediately.
- **Button held through reset deassertion:** treated as a fresh rising edge from the first post-reset edge.

## Timing
- **Reference edge k:** the first `clk` edge at which the synchronizer's first flop captures a new `btn_raw` level.
- **Rising latency, synchronizer compiled in:** `btn_db` rises after edge k+`DB_CYCLES`+2.
  - `btn_s` is valid after edge k+1.
  - `ST_RISE_CHK` is entered at edge k+2.
  - `ST_HIGH` is entered at edge k+`DB_CYCLES`+2.
- **Required hold:** `btn_s` must be 1 at every edge from k+2 through k+`DB_CYCLES`+2 (`DB_CYCLES`+1 samples) for acceptance.
- **Falling latency:** identical to rising.
- **Synchronizer compiled out:** every latency above shrinks by 1.
- **`bouncing` window:** high for the whole dwell in either CHK state, and falls in the same cycle that `btn_db` changes or the glitch is rejected.
- **Output to `button_sync`:** `btn_db` changes at most once per `DB_CYCLES`+1 cycles. `button_sync` therefore sees at most one rise per qualified press.

## Configuration
- **Macro `BUTTON_DEBOUNCE_SYNC_EN`:**
  - **Defined:** `btn_raw` passes through a two-flop synchronizer; `btn_s` is the second flop. This is the build for real pins.
  - **Undefined:** a single input register. `btn_s` is that register, and all latencies are reduced by 1 cycle. Used only when `btn_raw` is already synchronous to `clk`, e.g. from an upstream synchronous source in simulation.

## Structure
- **Shared package `button_pkg`** (shared with `button_sync`):
  - 2-bit state encodings `ST_LOW`=0, `ST_RISE_CHK`=1, `ST_HIGH`=2, `ST_FALL_CHK`=3.
  - Default `DB_CYCLES` constant.
- **Sub-module `sync_2ff`:** a generic 1-bit two-flop synchronizer with asynchronous active-high reset to 0. It is instantiated only under `BUTTON_DEBOUNCE_SYNC_EN`.
- **FSM and counter:** live in `button_debounce` itself, as a state register plus next-state and output logic.

## Test plan
All scenarios use `DB_CYCLES`=4 with `BUTTON_DEBOUNCE_SYNC_EN` defined unless stated otherwise.
1. **Reset values:** `rst`=1 with `btn_raw`=1 → `btn_db`=0 and `bouncing`=0 throughout reset. Release `rst` → `btn_db`=1 exactly 6 edges after the first post-reset edge.
2. **Clean press:** `btn_raw` 0→1 sampled at edge k → `bouncing`=1 after k+2, `btn_db`=1 after k+6, `bouncing`=0 after k+6. Downstream `button_sync` emits exactly one 1-cycle pulse.
3. **Rising bounce:** `btn_raw` toggles 1,0,1,0 on consecutive cycles, then holds 1 → `btn_db` rises only 6 edges after the final 0→1, never earlier. `bouncing` drops each time a 0 reaches `btn_s`.
4. **Release bounce:** from `ST_HIGH`, a 2-cycle low glitch → state returns to `ST_HIGH` and `btn_db` stays 1. A sustained release → `btn_db`=0 6 edges after the release edge.
5. **Reset mid-qualification:** assert `rst` while in `ST_RISE_CHK` with `cnt`=2 → immediately `ST_LOW`, `cnt`=0, outputs 0.
6. **Synchronizer compiled out, `DB_CYCLES`=1:** with `BUTTON_DEBOUNCE_SYNC_EN` undefined, a clean press → `btn_db`=1 after k+2. A single-cycle glitch → `btn_db` stays 0.
